// File: rtl/unlock_pkg.sv
// Shared types and constants for the button-sequence unlock controller.
// Button codes equal the BTN bit index: C=0, L=1, U=2, R=3.
package unlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_UNLOCK  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_e;

  localparam logic [1:0] BTN_CODE_C = 2'd0;
  localparam logic [1:0] BTN_CODE_L = 2'd1;
  localparam logic [1:0] BTN_CODE_U = 2'd2;
  localparam logic [1:0] BTN_CODE_R = 2'd3;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: 2-flop synchroniser, debounce counter and a one-cycle
// press pulse on an accepted rising level. Release edges produce nothing.
module btn_debounce
  import unlock_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int CNT_W = safe_clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any return to the accepted level restarts the qualification window.
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
        r_press  <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/btn_seq_unlock.sv
// Button-sequence unlock controller: debounced presses are matched against a
// code latched on ARM, with inter-press timeout, failure count and lockout.
module btn_seq_unlock
  import unlock_pkg::*;
#(
  parameter int SEQ_LEN      = 6,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TIMEOUT_CYC  = 500_000_000,
  parameter int MAX_FAILS    = 3,
  parameter int LOCKOUT_CYC  = 1_000_000_000
) (
  input  logic                               CLOCK_100MHz,
  input  logic                               RESET_N,
  input  logic [3:0]                         BTN,
  input  logic [2*SEQ_LEN-1:0]               CODE,
  input  logic                               ARM,
  input  logic                               RELOCK,
  output logic                               UNLOCKED,
  output logic                               LOCKED_OUT,
  output logic [$clog2(SEQ_LEN+1)-1:0]       STEP,
  output logic [1:0]                         EXP_CODE,
  output logic                               OK_PULSE,
  output logic                               FAIL_PULSE,
  output logic [$clog2(MAX_FAILS+1)-1:0]     FAIL_CNT
);

  localparam int STEP_W  = $clog2(SEQ_LEN + 1);
  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int TMR_MAX = (TIMEOUT_CYC > LOCKOUT_CYC) ? TIMEOUT_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = safe_clog2(TMR_MAX);

  localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  LCK_LAST  = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TMR_W-1:0]  TMR_SAT   = '1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SEQ_LEN - 1);
  localparam logic [FC_W-1:0]   FAIL_LIM  = FC_W'(MAX_FAILS);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [STEP_W-1:0]      r_step;
  logic [TMR_W-1:0]       r_timer;
  logic [FC_W-1:0]        r_fail_cnt;
  logic [2*SEQ_LEN-1:0]   r_code;
  logic                   r_ok;
  logic                   r_fail;

  logic [3:0]             w_press;
  logic                   w_any;
  logic                   w_one;
  logic [1:0]             w_code;
  logic [2*SEQ_LEN+1:0]   w_code_pad;
  logic [1:0]             w_exp;
  logic                   w_hit;
  logic                   w_expire;
  logic                   w_fail;
  logic                   w_last;
  logic [FC_W-1:0]        w_fail_inc;
  logic                   w_lock;
  logic                   w_lock_done;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
      .i_clk   (CLOCK_100MHz),
      .i_rst_n (RESET_N),
      .i_btn   (BTN[g]),
      .o_press (w_press[g])
    );
  end

  // NOTE: every always_comb output gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    w_any  = |w_press;
    w_one  = 1'b0;
    w_code = BTN_CODE_C;
    case (w_press)
      4'b0001: begin w_one = 1'b1; w_code = BTN_CODE_C; end
      4'b0010: begin w_one = 1'b1; w_code = BTN_CODE_L; end
      4'b0100: begin w_one = 1'b1; w_code = BTN_CODE_U; end
      4'b1000: begin w_one = 1'b1; w_code = BTN_CODE_R; end
      default: ;
    endcase
  end

  // Padding keeps the select in range when STEP sits at SEQ_LEN in UNLOCK.
  assign w_code_pad  = {2'b00, r_code};
  assign w_exp       = w_code_pad[{r_step, 1'b0} +: 2];
  assign w_hit       = w_one && (w_code == w_exp);
  assign w_expire    = !w_any && (r_step != '0) && (r_timer == TMO_LAST);
  assign w_fail      = (w_any && !w_hit) || w_expire;
  assign w_last      = (r_step == STEP_LAST);
  assign w_fail_inc  = r_fail_cnt + 1'b1;
  assign w_lock      = (w_fail_inc == FAIL_LIM);
  assign w_lock_done = (r_timer == LCK_LAST);

  always_ff @(posedge CLOCK_100MHz or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (ARM) w_next_state = ST_ENTRY;
      ST_ENTRY: begin
        if (w_hit && w_last)     w_next_state = ST_UNLOCK;
        else if (w_fail && w_lock) w_next_state = ST_LOCKOUT;
      end
      ST_UNLOCK:  if (RELOCK) w_next_state = ST_IDLE;
      ST_LOCKOUT: if (w_lock_done) w_next_state = ST_ENTRY;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    UNLOCKED   = (r_state == ST_UNLOCK);
    LOCKED_OUT = (r_state == ST_LOCKOUT);
    EXP_CODE   = (r_state == ST_ENTRY) ? w_exp : 2'b00;
  end

  // NOTE: the code register is reset with everything else; it is only a few
  // flops, and a defined value keeps EXP_CODE clean before the first ARM.
  always_ff @(posedge CLOCK_100MHz or negedge RESET_N) begin
    if (!RESET_N) begin
      r_step     <= '0;
      r_timer    <= '0;
      r_fail_cnt <= '0;
      r_code     <= '0;
      r_ok       <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_ok   <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ARM) begin
            r_code  <= CODE;
            r_step  <= '0;
            r_timer <= '0;
          end
        end
        ST_ENTRY: begin
          // A press in the expiry cycle wins; w_expire requires no press.
          if (w_hit) begin
            r_ok    <= 1'b1;
            r_step  <= r_step + 1'b1;
            r_timer <= '0;
            if (w_last) r_fail_cnt <= '0;
          end else if (w_fail) begin
            r_fail     <= 1'b1;
            r_step     <= '0;
            r_timer    <= '0;
            r_fail_cnt <= w_fail_inc;
          end else if (r_step != '0 && r_timer != TMR_SAT) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_UNLOCK: begin
          if (RELOCK) r_step <= '0;
        end
        ST_LOCKOUT: begin
          if (w_lock_done) begin
            r_timer    <= '0;
            r_step     <= '0;
            r_fail_cnt <= '0;
          end else if (r_timer != TMR_SAT) begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign STEP       = r_step;
  assign FAIL_CNT   = r_fail_cnt;
  assign OK_PULSE   = r_ok;
  assign FAIL_PULSE = r_fail;

endmodule

// File: tb/tb_btn_seq_unlock.sv
// Directed bench for btn_seq_unlock with SEQ_LEN=4, DEBOUNCE_CYC=4,
// TIMEOUT_CYC=100, MAX_FAILS=2, LOCKOUT_CYC=50.
module tb_btn_seq_unlock;

  localparam int SEQ_LEN = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn;
  logic [7:0] code;
  logic       arm;
  logic       relock;
  logic       UNLOCKED, LOCKED_OUT, OK_PULSE, FAIL_PULSE;
  logic [2:0] STEP;
  logic [1:0] EXP_CODE;
  logic [1:0] FAIL_CNT;

  int n_pass  = 0;
  int n_total = 0;

  btn_seq_unlock #(
    .SEQ_LEN      (SEQ_LEN),
    .DEBOUNCE_CYC (4),
    .TIMEOUT_CYC  (100),
    .MAX_FAILS    (2),
    .LOCKOUT_CYC  (50)
  ) dut (
    .CLOCK_100MHz (clk),
    .RESET_N      (rst_n),
    .BTN          (btn),
    .CODE         (code),
    .ARM          (arm),
    .RELOCK       (relock),
    .UNLOCKED     (UNLOCKED),
    .LOCKED_OUT   (LOCKED_OUT),
    .STEP         (STEP),
    .EXP_CODE     (EXP_CODE),
    .OK_PULSE     (OK_PULSE),
    .FAIL_PULSE   (FAIL_PULSE),
    .FAIL_CNT     (FAIL_CNT)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Fresh reset, load C,L,U,R, arm into ENTRY at STEP 0.
  task automatic reinit();
    btn = 4'b0; arm = 1'b0; relock = 1'b0; rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    code = 8'hE4;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
  endtask

  task automatic test_reset();
    btn = 4'b0; code = 8'hE4; arm = 1'b0; relock = 1'b0; rst_n = 1'b0;
    tick(3);
    n_total++; if ({UNLOCKED, LOCKED_OUT, OK_PULSE, FAIL_PULSE} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {UNLOCKED, LOCKED_OUT, OK_PULSE, FAIL_PULSE}); else n_pass++;
    n_total++; if ({STEP, EXP_CODE, FAIL_CNT} !== 7'b0) $display("FAIL reset_values: got %b exp 0", {STEP, EXP_CODE, FAIL_CNT}); else n_pass++;
    rst_n = 1'b1;
    btn = 4'b0001;
    tick(8);
    n_total++; if ({OK_PULSE, FAIL_PULSE, STEP} !== 5'b0) $display("FAIL idle_ignores_btn: got %b exp 0", {OK_PULSE, FAIL_PULSE, STEP}); else n_pass++;
    btn = 4'b0;
    tick(8);
  endtask

  task automatic test_correct_entry();
    reinit();
    code = 8'h00;  // must be ignored once loaded
    for (int i = 0; i < SEQ_LEN; i++) begin
      btn = 4'(1 << i);
      tick(7);
      n_total++; if (OK_PULSE !== 1'b1) $display("FAIL entry_ok%0d: got %b exp 1", i, OK_PULSE); else n_pass++;
      n_total++; if (STEP !== 3'(i + 1)) $display("FAIL entry_step%0d: got %0d exp %0d", i, STEP, i + 1); else n_pass++;
      if (i < SEQ_LEN - 1) begin
        n_total++; if (EXP_CODE !== 2'(i + 1)) $display("FAIL entry_exp%0d: got %0d exp %0d", i, EXP_CODE, i + 1); else n_pass++;
      end
      btn = 4'b0;
      tick(1);
      n_total++; if (OK_PULSE !== 1'b0) $display("FAIL entry_pulse_width%0d: got %b exp 0", i, OK_PULSE); else n_pass++;
      tick(7);
    end
    n_total++; if ({UNLOCKED, EXP_CODE, FAIL_CNT} !== 5'b10000) $display("FAIL unlocked: got %b exp 10000", {UNLOCKED, EXP_CODE, FAIL_CNT}); else n_pass++;
    btn = 4'b1000;
    tick(7);
    n_total++; if ({UNLOCKED, STEP, FAIL_PULSE} !== 5'b11000) $display("FAIL unlock_ignores_btn: got %b exp 11000", {UNLOCKED, STEP, FAIL_PULSE}); else n_pass++;
    btn = 4'b0;
    tick(8);
    relock = 1'b1;
    tick(1);
    relock = 1'b0;
    n_total++; if ({UNLOCKED, STEP} !== 4'b0) $display("FAIL relock: got %b exp 0000", {UNLOCKED, STEP}); else n_pass++;
  endtask

  task automatic test_bounce();
    int ok_seen = 0;
    int fail_seen = 0;
    reinit();
    for (int s = 0; s < 5; s++) begin
      btn[0] = (s % 2 == 0);
      repeat (2) begin
        tick(1);
        ok_seen += int'(OK_PULSE);
        fail_seen += int'(FAIL_PULSE);
      end
    end
    // The final high segment is the stable hold; 2 cycles of it are gone.
    tick(4);
    n_total++; if ({OK_PULSE, STEP} !== 4'b0 || ok_seen != 0) $display("FAIL bounce_early: ok=%b step=%0d seen=%0d exp 0", OK_PULSE, STEP, ok_seen); else n_pass++;
    tick(1);
    ok_seen += int'(OK_PULSE);
    n_total++; if ({OK_PULSE, STEP} !== 4'b1001) $display("FAIL bounce_event: ok=%b step=%0d exp ok=1 step=1", OK_PULSE, STEP); else n_pass++;
    repeat (10) begin
      tick(1);
      ok_seen += int'(OK_PULSE);
      fail_seen += int'(FAIL_PULSE);
    end
    n_total++; if (ok_seen != 1 || fail_seen != 0) $display("FAIL bounce_count: ok=%0d fail=%0d exp 1/0", ok_seen, fail_seen); else n_pass++;
    btn = 4'b0;
    tick(8);
  endtask

  task automatic test_wrong_lockout();
    reinit();
    code = 8'h55;  // must be ignored once loaded
    btn = 4'b0010;
    tick(7);
    n_total++; if ({FAIL_PULSE, FAIL_CNT, STEP, LOCKED_OUT} !== 7'b1_01_000_0) $display("FAIL wrong1: got %b exp 1010000", {FAIL_PULSE, FAIL_CNT, STEP, LOCKED_OUT}); else n_pass++;
    btn = 4'b0;
    tick(8);
    btn = 4'b0100;
    tick(7);
    n_total++; if ({FAIL_PULSE, FAIL_CNT, LOCKED_OUT} !== 4'b1_10_1) $display("FAIL wrong2_lock: got %b exp 1101", {FAIL_PULSE, FAIL_CNT, LOCKED_OUT}); else n_pass++;
    btn = 4'b0;
    tick(8);
    btn = 4'b0001;
    tick(7);
    n_total++; if ({OK_PULSE, STEP, LOCKED_OUT} !== 5'b0_000_1) $display("FAIL lockout_ignores_btn: got %b exp 00001", {OK_PULSE, STEP, LOCKED_OUT}); else n_pass++;
    btn = 4'b0;
    tick(8);
    tick(26);
    n_total++; if ({LOCKED_OUT, FAIL_CNT} !== 3'b1_10) $display("FAIL lockout_last_cycle: got %b exp 110", {LOCKED_OUT, FAIL_CNT}); else n_pass++;
    tick(1);
    n_total++; if ({LOCKED_OUT, FAIL_CNT, STEP, EXP_CODE} !== 8'b0) $display("FAIL lockout_exit: got %b exp 0", {LOCKED_OUT, FAIL_CNT, STEP, EXP_CODE}); else n_pass++;
    btn = 4'b0001;
    tick(7);
    n_total++; if ({OK_PULSE, STEP} !== 4'b1_001) $display("FAIL lockout_code_kept: got %b exp 1001", {OK_PULSE, STEP}); else n_pass++;
    btn = 4'b0;
    tick(8);
  endtask

  task automatic test_timeout();
    int fail_seen = 0;
    reinit();
    repeat (150) begin
      tick(1);
      fail_seen += int'(FAIL_PULSE);
    end
    n_total++; if (fail_seen != 0 || FAIL_CNT !== 2'd0) $display("FAIL no_timer_at_step0: fails=%0d cnt=%0d exp 0", fail_seen, FAIL_CNT); else n_pass++;
    btn = 4'b0001;
    tick(7);
    btn = 4'b0;
    tick(8);
    tick(91);
    n_total++; if ({FAIL_PULSE, STEP} !== 4'b0_001) $display("FAIL timeout_before: got %b exp 0001", {FAIL_PULSE, STEP}); else n_pass++;
    tick(1);
    n_total++; if ({FAIL_PULSE, STEP, FAIL_CNT} !== 6'b1_000_01) $display("FAIL timeout_fire: got %b exp 100001", {FAIL_PULSE, STEP, FAIL_CNT}); else n_pass++;

    reinit();
    btn = 4'b0001;
    tick(7);
    btn = 4'b0;
    tick(8);
    tick(85);
    btn = 4'b0010;  // press event lands in the expiry cycle
    tick(6);
    n_total++; if ({FAIL_PULSE, STEP} !== 4'b0_001) $display("FAIL expiry_pre: got %b exp 0001", {FAIL_PULSE, STEP}); else n_pass++;
    tick(1);
    n_total++; if ({OK_PULSE, FAIL_PULSE, STEP} !== 5'b1_0_010) $display("FAIL expiry_press_wins: got %b exp 10010", {OK_PULSE, FAIL_PULSE, STEP}); else n_pass++;
    btn = 4'b0;
    tick(8);
  endtask

  task automatic test_simultaneous();
    reinit();
    btn = 4'b0011;
    tick(7);
    n_total++; if ({OK_PULSE, FAIL_PULSE, STEP, FAIL_CNT} !== 7'b0_1_000_01) $display("FAIL simultaneous: got %b exp 0100001", {OK_PULSE, FAIL_PULSE, STEP, FAIL_CNT}); else n_pass++;
    btn = 4'b0;
    tick(8);
  endtask

  task automatic test_async_reset();
    reinit();
    btn = 4'b0001;
    tick(7);
    btn = 4'b0;
    tick(8);
    btn = 4'b0010;
    tick(7);
    btn = 4'b0;
    n_total++; if ({STEP, EXP_CODE} !== 5'b010_10) $display("FAIL pre_reset_step2: got %b exp 01010", {STEP, EXP_CODE}); else n_pass++;
    #3;
    rst_n = 1'b0;
    #1;
    n_total++; if ({UNLOCKED, LOCKED_OUT, STEP, EXP_CODE, OK_PULSE, FAIL_PULSE, FAIL_CNT} !== 11'b0) $display("FAIL async_reset: got %b exp 0", {UNLOCKED, LOCKED_OUT, STEP, EXP_CODE, OK_PULSE, FAIL_PULSE, FAIL_CNT}); else n_pass++;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    btn = 4'b0001;
    tick(7);
    n_total++; if ({OK_PULSE, FAIL_PULSE, STEP, EXP_CODE} !== 7'b0) $display("FAIL post_reset_idle: got %b exp 0", {OK_PULSE, FAIL_PULSE, STEP, EXP_CODE}); else n_pass++;
    btn = 4'b0;
    tick(8);
    code = 8'hE5;  // first element now L
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    n_total++; if (EXP_CODE !== 2'd1) $display("FAIL rearm_exp: got %0d exp 1", EXP_CODE); else n_pass++;
    btn = 4'b0010;
    tick(7);
    n_total++; if ({OK_PULSE, STEP} !== 4'b1_001) $display("FAIL rearm_press: got %b exp 1001", {OK_PULSE, STEP}); else n_pass++;
    btn = 4'b0;
    tick(8);
  endtask

  initial begin
    test_reset();
    test_correct_entry();
    test_bounce();
    test_wrong_lockout();
    test_timeout();
    test_simultaneous();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/btn_seq_unlock.md
# btn_seq_unlock

Parametrised button-sequence unlock controller: generalises the fixed six-step C-L-U-R-C-L lock into a configurable-length, runtime-loaded code with debounced inputs, inter-press timeout, failure counting and timed lockout. It sits between the raw board buttons (BTN_C/L/U/R) and the LED/7-segment display logic. It exports step and expected-code status, so the display layer can render progress.

## Interface
- SEQ_LEN, 6: number of presses in the code (1..16)
- DEBOUNCE_CYC, 1_000_000: cycles a synchronised button must hold a level to be accepted (10 ms at 100 MHz)
- TIMEOUT_CYC, 500_000_000: maximum cycles between accepted presses while in ENTRY (5 s)
- MAX_FAILS, 3: consecutive failures that trigger lockout (>=1)
- LOCKOUT_CYC, 1_000_000_000: lockout duration in cycles (10 s)
- CLOCK_100MHz  in  1  system clock; all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- BTN  in  4  raw buttons: [0]=C, [1]=L, [2]=U, [3]=R (2-bit code = bit index)
- CODE  in  2*SEQ_LEN  expected sequence; element i in CODE[2i+1:2i], i=0 first
- ARM  in  1  level; IDLE→ENTRY when high
- RELOCK  in  1  level; UNLOCK→IDLE when high
- UNLOCKED  out  1  high in UNLOCK
- LOCKED_OUT  out  1  high in LOCKOUT
- STEP  out  $clog2(SEQ_LEN+1)  count of correct presses so far
- EXP_CODE  out  2  code expected at STEP (0 outside ENTRY)
- OK_PULSE  out  1  one-cycle pulse per correct press
- FAIL_PULSE  out  1  one-cycle pulse per failure (wrong press or timeout)
- FAIL_CNT  out  $clog2(MAX_FAILS+1)  consecutive failures

## Operation
- Each BTN bit: 2-flop synchroniser → debouncer → rising-edge press event (one cycle).
- States: IDLE, ENTRY, UNLOCK, LOCKOUT.
- IDLE: buttons ignored; ARM=1 → load CODE into internal register, STEP=0, timer=0, → ENTRY. CODE changes after loading are ignored until next ARM.
- ENTRY, per cycle:
  - exactly one press event, matching code[STEP] → OK_PULSE, STEP+1, timer=0; if STEP+1==SEQ_LEN → UNLOCK, FAIL_CNT=0.
  - wrong single press, or two or more press events in the same cycle → failure.
  - no press and timer==TIMEOUT_CYC-1 → failure; the timer does not run while STEP==0.
  - failure: FAIL_PULSE, STEP=0, timer=0, FAIL_CNT+1; if the new count==MAX_FAILS → LOCKOUT, else stay in ENTRY.
- UNLOCK: buttons ignored; RELOCK=1 → IDLE, STEP=0.
- LOCKOUT: buttons ignored; timer counts to LOCKOUT_CYC-1, then → ENTRY with STEP=0, FAIL_CNT=0 (same code retained).
- ARM and RELOCK are ignored in states other than those listed.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0; debouncer stable levels 0; timers 0.
- Press latency: a raw BTN rising edge held stable yields a press event DEBOUNCE_CYC+2 cycles later. The FSM updates STEP, pulses and state on the next edge. A bounce shorter than DEBOUNCE_CYC restarts the count and produces no event.
- Release edges produce no event. Holding a button produces one event.
- A press event in the same cycle as a timeout expiry counts as a press; the timeout is discarded.
- UNLOCKED, LOCKED_OUT and STEP are registered state decodes. EXP_CODE is combinational from STEP and the stored code.
- Reset mid-ENTRY or mid-LOCKOUT: immediate return to IDLE. The lockout is not persisted.
- One shared timer, width $clog2(max(TIMEOUT_CYC, LOCKOUT_CYC)). It saturates and never wraps.

## Structure
- Package unlock_pkg holds:
  - the state enum
  - button code constants: BTN_CODE_C=0, L=1, U=2, R=3
- Sub-module btn_debounce (synchroniser, debounce counter, edge detector, parameter DEBOUNCE_CYC). It is instantiated 4× via generate.
- The FSM, shared timer and code register live in the top module.

## Test plan
All scenarios use SEQ_LEN=4, DEBOUNCE_CYC=4, TIMEOUT_CYC=100, MAX_FAILS=2, LOCKOUT_CYC=50.
- Correct entry: CODE = C,L,U,R; ARM; four clean presses → four OK_PULSEs, STEP 0→4. UNLOCKED=1 one cycle after the 4th press event; RELOCK → IDLE.
- Bounce: BTN[0] toggles every 2 cycles for 10 cycles, then holds → exactly one press event, 6 cycles after the stable hold begins.
- Wrong press then lockout: press L at STEP 0 → FAIL_PULSE, FAIL_CNT=1. Another wrong press → LOCKED_OUT=1. Presses for 50 cycles are ignored; then state is ENTRY with FAIL_CNT=0.
- Timeout: correct first press, then idle 100 cycles → FAIL_PULSE, STEP=0. A press in the expiry cycle instead advances STEP.
- Simultaneous presses: C and L press events in the same cycle at STEP 0 → failure, STEP stays 0.
- Async reset: assert RESET_N low mid-ENTRY at STEP=2 → all outputs 0 immediately, state IDLE after release.
